aq_sigcap_axi_lm: RTL and testbench

Local-bus to AXI4-Lite master bridge: the initiating end of the AXI4-Lite/local-bus link used by the sigcap register slave. A local requester (capture controller, test sequencer) presents CS/RNW/ADDR/BE/WDATA. The block issues one AXI4-Lite single-beat read or write, then returns ACK with RDATA and an error flag. One transaction is in flight at a time. No bursts and no outstanding pipelining.

---
 rtl/aq_axi_ls_pkg.sv | 26 ++
 rtl/aq_sigcap_axi_lm.sv | 180 ++++++++++++++++++
 tb/tb_aq_sigcap_axi_lm.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_axi_ls_pkg.sv
// Shared definitions for the sigcap AXI4-Lite master and slave.
package aq_axi_ls_pkg;

  // Bridge FSM encodings; the 4-bit code is exported on DEBUG[3:0].
  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StWrite   = 4'd1,
    StWresp   = 4'd2,
    StRead    = 4'd3,
    StRdata   = 4'd4,
    StAck     = 4'd5,
    StRelease = 4'd6
  } axi_ls_state_e;

  // AXI response codes.
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // Anything other than OKAY is reported to the local requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/aq_sigcap_axi_lm.sv
// Local-bus to AXI4-Lite master bridge: one single-beat transaction at a time.
module aq_sigcap_axi_lm
  import aq_axi_ls_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [3:0]  AXI_CACHE  = 4'b0011,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // Local requester side
  input  logic                  LOCAL_CS,
  input  logic                  LOCAL_RNW,
  input  logic [ADDR_WIDTH-1:0] LOCAL_ADDR,
  input  logic [3:0]            LOCAL_BE,
  input  logic [31:0]           LOCAL_WDATA,
  output logic                  LOCAL_ACK,
  output logic [31:0]           LOCAL_RDATA,
  output logic                  LOCAL_ERR,
  // Write address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  // Write data channel
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  // Write response channel
  input  logic                  M_AXI_BVALID,
  input  logic [1:0]            M_AXI_BRESP,
  output logic                  M_AXI_BREADY,
  // Read address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  // Read data channel
  input  logic                  M_AXI_RVALID,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  output logic                  M_AXI_RREADY,
  // Debug
  output logic [31:0]           DEBUG
);

  axi_ls_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  rnw_q;
  logic                  awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                  aw_done_q, w_done_q;
  logic                  ack_q, err_q;
  logic [31:0]           rdata_q;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;

  // Transaction FSM; every handshake output is a register set on state entry.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rnw_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (LOCAL_CS) begin
            addr_q  <= LOCAL_ADDR;
            wdata_q <= LOCAL_WDATA;
            be_q    <= LOCAL_BE;
            rnw_q   <= LOCAL_RNW;
            if (LOCAL_RNW) begin
              arvalid_q <= 1'b1;
              state_q   <= StRead;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= StWrite;
            end
          end
        end
        StWrite: begin
          // Address and data retire independently, in either order.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= StWresp;
          end
        end
        StWresp: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            err_q    <= resp_is_err(M_AXI_BRESP);
            ack_q    <= 1'b1;
            state_q  <= StAck;
          end
        end
        StRead: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            rdata_q  <= M_AXI_RDATA;
            err_q    <= resp_is_err(M_AXI_RRESP);
            ack_q    <= 1'b1;
            state_q  <= StAck;
          end
        end
        StAck: begin
          state_q <= StRelease;
        end
        StRelease: begin
          // A request left asserted is not re-executed; CS must drop first.
          if (!LOCAL_CS) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign LOCAL_ACK     = ack_q;
  assign LOCAL_RDATA   = rdata_q;
  assign LOCAL_ERR     = err_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWCACHE = AXI_CACHE;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = be_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARCACHE = AXI_CACHE;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  assign DEBUG = {24'd0, (state_q != StIdle), err_q, ack_q, rnw_q, state_q};

endmodule

// File: tb/tb_aq_sigcap_axi_lm.sv
// Bench for aq_sigcap_axi_lm: delay-programmable AXI4-Lite slave, protocol
// monitor and a scoreboard of expected completions.
module tb_aq_sigcap_axi_lm;
  import aq_axi_ls_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic        LOCAL_CS, LOCAL_RNW;
  logic [31:0] LOCAL_ADDR, LOCAL_WDATA;
  logic [3:0]  LOCAL_BE;
  logic        LOCAL_ACK, LOCAL_ERR;
  logic [31:0] LOCAL_RDATA;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA, DEBUG;
  logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  aq_sigcap_axi_lm dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ADDR(LOCAL_ADDR),
    .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA), .LOCAL_ACK(LOCAL_ACK),
    .LOCAL_RDATA(LOCAL_RDATA), .LOCAL_ERR(LOCAL_ERR),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RREADY(M_AXI_RREADY),
    .DEBUG(DEBUG)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour knobs, changed only between transactions.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] rd_value = '0;
  logic [1:0]  rresp = RespOkay, bresp = RespOkay;
  logic [31:0] rdata_hold = '0;

  // Slave and monitor state.
  int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
  logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, b_hs_q = 0, r_hs_q = 0;
  int          aw_count = 0, b_count = 0, ack_count = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        prev_rst = 1'b1, prev_ack = 1'b0;
  logic        prev_awvalid = 0, prev_aw_hs = 0, prev_wvalid = 0, prev_w_hs = 0;
  logic        prev_arvalid = 0, prev_ar_hs = 0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_araddr = '0;
  logic [3:0]  prev_wstrb = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One slave/monitor cycle, evaluated at the falling edge.
  task automatic slave_step();
    logic aw_hs, w_hs, ar_hs;
    exp_t e;
    if (ARESET) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_hs_q = 0; r_hs_q = 0;
      prev_rst = 1; prev_ack = 0;
      return;
    end
    if (!prev_rst) begin
      if (prev_awvalid && !prev_aw_hs) begin
        check("aw_valid_hold", 32'(M_AXI_AWVALID), 32'd1);
        check("aw_addr_stable", M_AXI_AWADDR, prev_awaddr);
      end
      if (prev_wvalid && !prev_w_hs) begin
        check("w_valid_hold", 32'(M_AXI_WVALID), 32'd1);
        check("w_data_stable", M_AXI_WDATA, prev_wdata);
        check("w_strb_stable", 32'(M_AXI_WSTRB), 32'(prev_wstrb));
      end
      if (prev_arvalid && !prev_ar_hs) begin
        check("ar_valid_hold", 32'(M_AXI_ARVALID), 32'd1);
        check("ar_addr_stable", M_AXI_ARADDR, prev_araddr);
      end
      if (prev_ack) check("ack_one_cycle", 32'(LOCAL_ACK), 32'd0);
    end
    if (LOCAL_ACK) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", 32'(LOCAL_ACK), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rdata", LOCAL_RDATA, e.rdata);
        check("sb_err", 32'(LOCAL_ERR), 32'(e.err));
        if (e.rnw) begin
          check("sb_araddr", cap_araddr, e.addr);
        end else begin
          check("sb_awaddr", cap_awaddr, e.addr);
          check("sb_wdata", cap_wdata, e.wdata);
          check("sb_wstrb", 32'(cap_wstrb), 32'(e.be));
        end
      end
    end
    // Retire responses handshaken at the last rising edge.
    if (b_hs_q) begin M_AXI_BVALID = 0; b_pend = 0; b_count++; b_hs_q = 0; end
    if (r_hs_q) begin M_AXI_RVALID = 0; r_pend = 0; r_hs_q = 0; end
    if (b_pend && !M_AXI_BVALID) begin
      if (b_wait >= b_dly) begin M_AXI_BVALID = 1; M_AXI_BRESP = bresp; end
      else b_wait++;
    end
    if (r_pend && !M_AXI_RVALID) begin
      if (r_wait >= r_dly) begin
        M_AXI_RVALID = 1; M_AXI_RDATA = rd_value; M_AXI_RRESP = rresp;
      end else r_wait++;
    end
    b_hs_q = M_AXI_BVALID && M_AXI_BREADY;
    r_hs_q = M_AXI_RVALID && M_AXI_RREADY;
    // Request channels: READY after the programmed number of VALID cycles.
    if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_wait >= aw_dly); aw_wait++; end
    else begin M_AXI_AWREADY = 0; aw_wait = 0; end
    if (M_AXI_WVALID) begin M_AXI_WREADY = (w_wait >= w_dly); w_wait++; end
    else begin M_AXI_WREADY = 0; w_wait = 0; end
    if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_wait_ok()); end
    else begin M_AXI_ARREADY = 0; end
    aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    if (aw_hs) begin cap_awaddr = M_AXI_AWADDR; aw_got = 1; aw_count++; end
    if (w_hs) begin cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; w_got = 1; end
    if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
    if (ar_hs) begin cap_araddr = M_AXI_ARADDR; r_pend = 1; r_wait = 0; end
    prev_awvalid = M_AXI_AWVALID; prev_aw_hs = aw_hs; prev_awaddr = M_AXI_AWADDR;
    prev_wvalid = M_AXI_WVALID; prev_w_hs = w_hs;
    prev_wdata = M_AXI_WDATA; prev_wstrb = M_AXI_WSTRB;
    prev_arvalid = M_AXI_ARVALID; prev_ar_hs = ar_hs; prev_araddr = M_AXI_ARADDR;
    prev_ack = LOCAL_ACK;
    prev_rst = 0;
  endtask

  int ar_wait = 0;
  function automatic logic ar_wait_ok();
    logic ok;
    ok = (ar_wait >= ar_dly);
    ar_wait = ok ? 0 : ar_wait + 1;
    return ok;
  endfunction

  initial begin
    forever begin
      @(negedge ACLK);
      slave_step();
    end
  end

  // Drive a request and record what its completion must look like.
  task automatic start_txn(input logic rnw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.rnw = rnw; e.addr = addr; e.wdata = wdata; e.be = be;
    if (rnw) begin
      e.rdata = rd_value; e.err = (rresp != RespOkay); rdata_hold = rd_value;
    end else begin
      e.rdata = rdata_hold; e.err = (bresp != RespOkay);
    end
    sb_q.push_back(e);
    LOCAL_RNW = rnw; LOCAL_ADDR = addr; LOCAL_WDATA = wdata; LOCAL_BE = be;
    LOCAL_CS = 1'b1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (LOCAL_ACK) break;
    end
    check("ack_seen", 32'(LOCAL_ACK), 32'd1);
  endtask

  task automatic finish_txn();
    LOCAL_CS = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_txn(input logic rnw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    start_txn(rnw, addr, wdata, be);
    wait_ack();
    finish_txn();
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int b_before, aw_before, ack_before;

  initial begin
    ARESET = 1'b1; LOCAL_CS = 0; LOCAL_RNW = 0; LOCAL_ADDR = '0; LOCAL_WDATA = '0;
    LOCAL_BE = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0;
    M_AXI_RVALID = 0; M_AXI_BRESP = '0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
    repeat (3) tick();
    check("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 32'd0);
    check("rst_readies", 32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    check("rst_ack_err", 32'({LOCAL_ACK, LOCAL_ERR}), 32'd0);
    check("rst_rdata", LOCAL_RDATA, 32'd0);
    check("rst_debug", DEBUG, 32'd0);
    ARESET = 1'b0;
    tick();

    // 1: zero-wait write, cycle-exact
    set_dly(0, 0, 0, 0, 0); bresp = RespOkay;
    start_txn(1'b0, 32'h0000_0010, 32'hA5A5_1234, 4'hF);
    tick();
    check("t1_c1_awvalid", 32'(M_AXI_AWVALID), 32'd1);
    check("t1_c1_wvalid", 32'(M_AXI_WVALID), 32'd1);
    check("t1_c1_awaddr", M_AXI_AWADDR, 32'h0000_0010);
    check("t1_c1_wdata", M_AXI_WDATA, 32'hA5A5_1234);
    check("t1_c1_wstrb", 32'(M_AXI_WSTRB), 32'hF);
    check("t1_c1_cache", 32'(M_AXI_AWCACHE), 32'h3);
    check("t1_c1_state", 32'(DEBUG[3:0]), 32'(StWrite));
    tick();
    check("t1_c2_bready", 32'(M_AXI_BREADY), 32'd1);
    check("t1_c2_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    tick();
    check("t1_c3_ack", 32'(LOCAL_ACK), 32'd1);
    check("t1_c3_err", 32'(LOCAL_ERR), 32'd0);
    LOCAL_CS = 1'b0;
    tick();
    check("t1_c4_release", 32'(DEBUG[3:0]), 32'(StRelease));
    tick();
    check("t1_c5_idle", 32'(DEBUG[7:0]), 32'd0);

    // 2: W accepted at cycle 1, AW at cycle 4
    set_dly(3, 0, 0, 0, 0);
    b_before = b_count;
    start_txn(1'b0, 32'h0000_0014, 32'h0BAD_F00D, 4'h3);
    tick();
    check("t2_c1_wvalid", 32'(M_AXI_WVALID), 32'd1);
    tick();
    check("t2_c2_wvalid", 32'(M_AXI_WVALID), 32'd0);
    check("t2_c2_awvalid", 32'(M_AXI_AWVALID), 32'd1);
    tick();
    check("t2_c3_awvalid", 32'(M_AXI_AWVALID), 32'd1);
    tick();
    check("t2_c4_awvalid", 32'(M_AXI_AWVALID), 32'd1);
    check("t2_c4_state", 32'(DEBUG[3:0]), 32'(StWrite));
    tick();
    check("t2_c5_state", 32'(DEBUG[3:0]), 32'(StWresp));
    wait_ack();
    finish_txn();
    check("t2_b_handshakes", 32'(b_count - b_before), 32'd1);

    // 3: stalled read with SLVERR, then a write must not touch RDATA
    set_dly(0, 0, 0, 3, 2); rd_value = 32'hDEAD_BEEF; rresp = RespSlverr;
    ack_before = ack_count;
    do_txn(1'b1, 32'h0000_0020, 32'h0, 4'hF);
    check("t3_ack_once", 32'(ack_count - ack_before), 32'd1);
    check("t3_rdata", LOCAL_RDATA, 32'hDEAD_BEEF);
    check("t3_err_held", 32'(LOCAL_ERR), 32'd1);
    set_dly(0, 0, 0, 0, 0); bresp = RespOkay;
    do_txn(1'b0, 32'h0000_0024, 32'h5555_AAAA, 4'hF);
    check("t3_rdata_kept", LOCAL_RDATA, 32'hDEAD_BEEF);
    check("t3_err_cleared", 32'(LOCAL_ERR), 32'd0);

    // 4: CS held after ACK must not re-execute
    aw_before = aw_count; ack_before = ack_count;
    start_txn(1'b0, 32'h0000_0030, 32'h1111_2222, 4'hF);
    wait_ack();
    repeat (8) tick();
    check("t4_state_release", 32'(DEBUG[3:0]), 32'(StRelease));
    check("t4_aw_once", 32'(aw_count - aw_before), 32'd1);
    check("t4_ack_once", 32'(ack_count - ack_before), 32'd1);
    LOCAL_CS = 1'b0;
    tick();
    start_txn(1'b0, 32'h0000_0030, 32'h1111_2222, 4'hF);
    wait_ack();
    finish_txn();
    check("t4_aw_twice", 32'(aw_count - aw_before), 32'd2);
    check("t4_ack_twice", 32'(ack_count - ack_before), 32'd2);

    // 5: reset while the write address is stalled
    set_dly(20, 20, 0, 0, 0);
    LOCAL_RNW = 1'b0; LOCAL_ADDR = 32'h0000_0038; LOCAL_WDATA = 32'hCAFE_0001;
    LOCAL_BE = 4'hF; LOCAL_CS = 1'b1;
    repeat (4) tick();
    check("t5_stalled", 32'(M_AXI_AWVALID), 32'd1);
    ARESET = 1'b1;
    tick();
    check("t5_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    check("t5_wvalid", 32'(M_AXI_WVALID), 32'd0);
    check("t5_ack", 32'(LOCAL_ACK), 32'd0);
    check("t5_rdata", LOCAL_RDATA, 32'd0);
    check("t5_state", 32'(DEBUG[3:0]), 32'(StIdle));
    ARESET = 1'b0; LOCAL_CS = 1'b0; rdata_hold = '0;
    tick();
    set_dly(0, 0, 0, 0, 0); rd_value = 32'h1234_5678; rresp = RespOkay;
    do_txn(1'b1, 32'h0000_0040, 32'h0, 4'hF);
    check("t5_post_read", LOCAL_RDATA, 32'h1234_5678);

    // 6: read/write/read with random slave timing
    ack_before = ack_count;
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 3; k++) begin
        set_dly($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
        rd_value = $urandom;
        rresp = 2'($urandom_range(0, 3));
        bresp = (k == 1 && round == 1) ? RespDecerr : 2'($urandom_range(0, 1));
        do_txn((k != 1), {$urandom_range(0, 255), 2'b00} & 32'h3FC, $urandom,
               4'($urandom_range(1, 15)));
      end
    end
    check("t6_ack_per_cs", 32'(ack_count - ack_before), 32'd9);
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);
    check("t6_exokay_code", 32'(RespExokay != RespOkay), 32'(resp_is_err(2'b01)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
